// File: rtl/ac_matmul_sequencer_if.sv
// Memory request port of the matmul sequencer: the sequencer is master, the word memory is slave.
interface ac_matmul_sequencer_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_ack;

    modport master (output mem_addr, mem_rd, mem_wr, input mem_ack);
    modport slave  (input mem_addr, mem_rd, mem_wr, output mem_ack);
endinterface

// File: rtl/ac_matmul_sequencer.sv
// Control FSM sequencing the AC datapath through C = A x B for NxN word matrices.
// ACSEQ_PERF_CNT_EN adds a saturating busy-cycle counter on cycles_out.
module ac_matmul_sequencer #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned DIM_W     = 4,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DIM_W-1:0]      dim,
    input  logic [ADDR_W-1:0]     base_a,
    input  logic [ADDR_W-1:0]     base_b,
    input  logic [ADDR_W-1:0]     base_c,
    ac_matmul_sequencer_if.master mem,
    output logic                  tr_load,
    output logic                  ac_zero,
    output logic                  ac_alu_to_ac,
    output logic                  ac_out_en,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           cycles_out
);

    if (WORD_SIZE == 0 || DIM_W > ADDR_W) begin : g_param_err
        $error("ac_matmul_sequencer: bad WORD_SIZE/DIM_W/ADDR_W");
    end

    typedef enum logic [2:0] {StIdle, StClr, StRdA, StRdB, StStore, StDone} state_e;

    state_e            state_q, state_d;
    logic [DIM_W-1:0]  dim_q, dim_d;
    logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ADDR_W-1:0] base_b_q, base_b_d;
    logic [ADDR_W-1:0] a_row_q, a_row_d, a_ptr_q, a_ptr_d;
    logic [ADDR_W-1:0] b_ptr_q, b_ptr_d, c_ptr_q, c_ptr_d;

    logic [ADDR_W-1:0] dim_ext;
    logic [DIM_W-1:0]  last_idx;
    logic              acked;

    assign dim_ext  = ADDR_W'(dim_q);
    assign last_idx = dim_q - DIM_W'(1);
    // An ack coinciding with abort must not advance anything.
    assign acked    = mem.mem_ack && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            dim_q    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            base_b_q <= '0;
            a_row_q  <= '0;
            a_ptr_q  <= '0;
            b_ptr_q  <= '0;
            c_ptr_q  <= '0;
        end else begin
            state_q  <= state_d;
            dim_q    <= dim_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            base_b_q <= base_b_d;
            a_row_q  <= a_row_d;
            a_ptr_q  <= a_ptr_d;
            b_ptr_q  <= b_ptr_d;
            c_ptr_q  <= c_ptr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dim_d        = dim_q;
        i_d          = i_q;
        j_d          = j_q;
        k_d          = k_q;
        base_b_d     = base_b_q;
        a_row_d      = a_row_q;
        a_ptr_d      = a_ptr_q;
        b_ptr_d      = b_ptr_q;
        c_ptr_d      = c_ptr_q;
        mem.mem_addr = '0;
        mem.mem_rd   = 1'b0;
        mem.mem_wr   = 1'b0;
        tr_load      = 1'b0;
        ac_zero      = 1'b0;
        ac_alu_to_ac = 1'b0;
        ac_out_en    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dim_d    = dim;
                    base_b_d = base_b;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    a_row_d  = base_a;
                    a_ptr_d  = base_a;
                    b_ptr_d  = base_b;
                    c_ptr_d  = base_c;
                    state_d  = (dim == '0) ? StDone : StClr;
                end
            end
            StClr: begin
                busy    = 1'b1;
                ac_zero = 1'b1;
                state_d = abort ? StIdle : StRdA;
            end
            StRdA: begin
                busy         = 1'b1;
                mem.mem_rd   = 1'b1;
                mem.mem_addr = a_ptr_q;
                tr_load      = acked;
                if (abort) begin
                    state_d = StIdle;
                end else if (acked) begin
                    a_ptr_d = a_ptr_q + ADDR_W'(1);
                    state_d = StRdB;
                end
            end
            StRdB: begin
                busy         = 1'b1;
                mem.mem_rd   = 1'b1;
                mem.mem_addr = b_ptr_q;
                ac_alu_to_ac = acked;
                if (abort) begin
                    state_d = StIdle;
                end else if (acked) begin
                    b_ptr_d = b_ptr_q + dim_ext;
                    k_d     = k_q + DIM_W'(1);
                    state_d = (k_q == last_idx) ? StStore : StRdA;
                end
            end
            StStore: begin
                busy         = 1'b1;
                mem.mem_wr   = 1'b1;
                mem.mem_addr = c_ptr_q;
                ac_out_en    = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else if (acked) begin
                    c_ptr_d = c_ptr_q + ADDR_W'(1);
                    k_d     = '0;
                    if (j_q != last_idx) begin
                        // Next column of the same row of C.
                        j_d     = j_q + DIM_W'(1);
                        a_ptr_d = a_row_q;
                        b_ptr_d = base_b_q + ADDR_W'(j_q) + ADDR_W'(1);
                        state_d = StClr;
                    end else if (i_q != last_idx) begin
                        i_d     = i_q + DIM_W'(1);
                        j_d     = '0;
                        a_row_d = a_row_q + dim_ext;
                        a_ptr_d = a_row_q + dim_ext;
                        b_ptr_d = base_b_q;
                        state_d = StClr;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef ACSEQ_PERF_CNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= '0;
        end else if (state_q == StIdle && start) begin
            cyc_q <= '0;
        end else if (busy && cyc_q != 32'hFFFF_FFFF) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign cycles_out = cyc_q;
`else
    assign cycles_out = '0;
`endif

endmodule
